// File: rtl/skolem_chk_pkg.sv
// Shared definitions for the Skolem-function equivalence checker:
// FSM state encoding, default operand width and derived vector/count widths.
package skolem_chk_pkg;

    localparam int W_DEFAULT = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SCAN,
        ST_COMPARE,
        ST_DONE
    } state_e;

    // Skolem input vector is {t, s}; the counter must hold every vector without wrapping
    function automatic int vec_width(input int w);
        return 2 * w;
    endfunction

    function automatic int cnt_width(input int w);
        return 2 * w + 1;
    endfunction

    localparam int VEC_W_DEFAULT = 2 * W_DEFAULT;
    localparam int CNT_W_DEFAULT = 2 * W_DEFAULT + 1;

endpackage

// File: rtl/bv_urem.sv
// Combinational unsigned remainder; remainder by zero returns the dividend.
module bv_urem #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] r
);

    always_comb begin
        r = (b == '0) ? a : (a % b);
    end

endmodule

// File: rtl/skolem_equiv_checker.sv
// Exhaustively sweeps every (s,t) vector, computes the golden existential value
// one x per cycle, and compares it with the Skolem function's returned bit.
module skolem_equiv_checker
    import skolem_chk_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic [vec_width(W)-1:0] sk_in,
    input  logic                    sk_out,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [cnt_width(W)-1:0] mismatch_cnt,
    output logic [vec_width(W)-1:0] first_fail,
    output logic                    first_fail_valid
);

    localparam int VW = vec_width(W);
    localparam int CW = cnt_width(W);

    state_e          state_q, state_d;
    logic [VW-1:0]   v_q, v_d;
    logic [W-1:0]    x_q, x_d;
    logic            exist_q, exist_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [VW-1:0]   ff_q, ff_d;
    logic            ffv_q, ffv_d;
    logic            pass_q, pass_d;
    logic            done_q, done_d;

    logic [W-1:0]    s_val;
    logic [W-1:0]    t_val;
    logic [W-1:0]    rem;

    assign s_val = v_q[W-1:0];
    assign t_val = v_q[VW-1:W];

    bv_urem #(.W(W)) u_urem (
        .a (x_q),
        .b (s_val),
        .r (rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            v_q     <= '0;
            x_q     <= '0;
            exist_q <= 1'b0;
            cnt_q   <= '0;
            ff_q    <= '0;
            ffv_q   <= 1'b0;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            x_q     <= x_d;
            exist_q <= exist_d;
            cnt_q   <= cnt_d;
            ff_q    <= ff_d;
            ffv_q   <= ffv_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        x_d     = x_q;
        exist_d = exist_q;
        cnt_d   = cnt_q;
        ff_d    = ff_q;
        ffv_d   = ffv_q;
        pass_d  = pass_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    v_d     = '0;
                    cnt_d   = '0;
                    ffv_d   = 1'b0;
                    pass_d  = 1'b0;
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: begin
                exist_d = 1'b0;
                x_d     = '0;
                state_d = ST_SCAN;
            end
            ST_SCAN: begin
                // Full scan of all x every vector, no early exit, so latency is fixed
                exist_d = exist_q | (rem > t_val);
                x_d     = x_q + 1'b1;
                if (x_q == '1) begin
                    state_d = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (sk_out != exist_q) begin
                    cnt_d = cnt_q + 1'b1;
                    if (!ffv_q) begin
                        ff_d  = v_q;
                        ffv_d = 1'b1;
                    end
                end
                if (v_q == '1) begin
                    state_d = ST_DONE;
                end else begin
                    v_d     = v_q + 1'b1;
                    state_d = ST_APPLY;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                pass_d  = (cnt_q == '0);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign sk_in            = v_q;
    assign busy             = (state_q != ST_IDLE);
    assign done             = done_q;
    assign pass             = pass_q;
    assign mismatch_cnt     = cnt_q;
    assign first_fail       = ff_q;
    assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_skolem_equiv_checker.sv
// Scoreboard bench for skolem_equiv_checker: directed sweeps with a behavioural
// Skolem function model, expected results queued at start and checked on done.
module tb_skolem_equiv_checker;

    localparam int W  = 4;
    localparam int VW = 2 * W;
    localparam int CW = 2 * W + 1;
    localparam int DONE_LAT = 4609;
    localparam int WAIT_BOUND = 6000;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [VW-1:0] sk_in;
    logic          sk_out;
    logic          busy;
    logic          done;
    logic          pass;
    logic [CW-1:0] mismatch_cnt;
    logic [VW-1:0] first_fail;
    logic          first_fail_valid;

    typedef struct {
        int cnt;
        int ff;
        int ffv;
        int pass;
        int lat;
    } exp_t;

    exp_t sb_q[$];

    int checks     = 0;
    int fails      = 0;
    int edge_cnt   = 0;
    int start_edge = 0;
    int done_seen  = 0;
    int mode       = 0;
    bit prev_done  = 0;

    skolem_equiv_checker #(.W(W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .sk_in            (sk_in),
        .sk_out           (sk_out),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .mismatch_cnt     (mismatch_cnt),
        .first_fail       (first_fail),
        .first_fail_valid (first_fail_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Reference: does some x in 0..15 have (x urem s) > t, with x urem 0 = x
    function automatic bit golden(input logic [VW-1:0] v);
        int s;
        int t;
        int r;
        bit e;
        s = int'(v[W-1:0]);
        t = int'(v[VW-1:W]);
        e = 1'b0;
        for (int x = 0; x < (1 << W); x++) begin
            r = (s == 0) ? x : (x % s);
            if (r > t) e = 1'b1;
        end
        return e;
    endfunction

    // Skolem function under test: 0 golden, 1 stuck-0, 2 stuck-1, 3 golden inverted at 0x5A
    always_comb begin
        sk_out = golden(sk_in);
        case (mode)
            1: sk_out = 1'b0;
            2: sk_out = 1'b1;
            3: sk_out = golden(sk_in) ^ (sk_in == 8'h5A);
            default: sk_out = golden(sk_in);
        endcase
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    // Monitor: pops one expectation per done pulse
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_done) checkOutput("done_single_pulse", int'(done), 0);
            if (done) begin
                done_seen++;
                checkOutput("done_expected", sb_q.size(), 1);
                if (sb_q.size() > 0) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    checkOutput("done_latency", edge_cnt - start_edge, e.lat);
                    checkOutput("mismatch_cnt", int'(mismatch_cnt), e.cnt);
                    checkOutput("first_fail_valid", int'(first_fail_valid), e.ffv);
                    if (e.ffv != 0) checkOutput("first_fail", int'(first_fail), e.ff);
                    checkOutput("pass", int'(pass), e.pass);
                    checkOutput("busy_at_done", int'(busy), 0);
                end
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic applyStimulus(input int m, input bit push, input int cnt,
                                 input int ff, input int ffv, input int ps);
        exp_t e;
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        if (push) begin
            e.cnt  = cnt;
            e.ff   = ff;
            e.ffv  = ffv;
            e.pass = ps;
            e.lat  = DONE_LAT;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        start_edge = edge_cnt;
        start      = 1'b0;
    endtask

    task automatic waitDone(input string name);
        int seen0;
        int n;
        seen0 = done_seen;
        n = 0;
        while (done_seen == seen0 && n < WAIT_BOUND) begin
            @(negedge clk);
            n++;
        end
        if (done_seen == seen0) begin
            checks++;
            fails++;
            $display("[TB] FAIL %s: done not seen within %0d cycles, expected at %0d",
                     name, WAIT_BOUND, DONE_LAT);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_sk_in"}, int'(sk_in), 0);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_done"}, int'(done), 0);
        checkOutput({tag, "_pass"}, int'(pass), 0);
        checkOutput({tag, "_mismatch_cnt"}, int'(mismatch_cnt), 0);
        checkOutput({tag, "_first_fail"}, int'(first_fail), 0);
        checkOutput({tag, "_first_fail_valid"}, int'(first_fail_valid), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 0;
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle_without_start", int'(busy), 0);

        $display("[TB] golden Skolem function");
        applyStimulus(0, 1'b1, 0, 0, 0, 1);
        @(negedge clk);
        checkOutput("busy_running", int'(busy), 1);
        checkOutput("sk_in_first_vector", int'(sk_in), 0);
        waitDone("golden");

        $display("[TB] stuck-at-0 output");
        applyStimulus(1, 1'b1, 120, 8'h00, 1, 0);
        waitDone("stuck0");

        $display("[TB] stuck-at-1 output");
        applyStimulus(2, 1'b1, 136, 8'h01, 1, 0);
        waitDone("stuck1");

        $display("[TB] single inverted vector 0x5A");
        applyStimulus(3, 1'b1, 1, 8'h5A, 1, 0);
        waitDone("invert_5a");

        $display("[TB] second start while busy");
        applyStimulus(0, 1'b1, 0, 0, 0, 1);
        repeat (100) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_after_extra_start", int'(busy), 1);
        waitDone("restart_ignored");

        $display("[TB] reset mid-sweep");
        applyStimulus(0, 1'b0, 0, 0, 0, 0);
        repeat (2001) @(negedge clk);
        checkOutput("busy_before_reset", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("idle_after_reset", int'(busy), 0);
        applyStimulus(0, 1'b1, 0, 0, 0, 1);
        waitDone("after_reset");

        checkOutput("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
